// File: rtl/imm_extend_pipe_if.sv
// Request/response bundle for imm_extend_pipe: decode-side request handshake,
// execute-side result handshake and the error status outputs.
interface imm_extend_pipe_if #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned ERR_CNT_W = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          Imm32;
   logic [2:0]           Ctrl;
   logic [DATA_W-1:0]    Merge;
   logic                 out_valid;
   logic                 out_ready;
   logic [DATA_W-1:0]    BusImm;
   logic                 out_err;
   logic                 err_sticky;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport master (
      output in_valid, Imm32, Ctrl, Merge, out_ready,
      input  in_ready, out_valid, BusImm, out_err, err_sticky, err_cnt
   );

   modport slave (
      input  in_valid, Imm32, Ctrl, Merge, out_ready,
      output in_ready, out_valid, BusImm, out_err, err_sticky, err_cnt
   );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: decodes I/D/B/CB/move-wide immediates into a
// registered DATA_W result behind a valid/ready handshake with a one-entry skid buffer.
module imm_extend_pipe #(
   parameter int unsigned DATA_W    = 64,
   parameter bit          SCALE_BR  = 1'b1,
   parameter int unsigned ERR_CNT_W = 8
) (
   input logic              CLK,
   input logic              Reset,
   imm_extend_pipe_if.slave bus
);

   typedef enum logic [2:0] {
      FMT_I   = 3'b000,
      FMT_D   = 3'b001,
      FMT_B   = 3'b010,
      FMT_CB  = 3'b011,
      FMT_MZ  = 3'b100,
      FMT_MK  = 3'b101,
      FMT_MN  = 3'b110,
      FMT_ILL = 3'b111
   } fmt_e;

   localparam bit          NARROW = (DATA_W == 32);
   localparam int unsigned BR_SH  = SCALE_BR ? 2 : 0;

   // decode datapath
   fmt_e              fmt;
   logic [1:0]        hw;
   logic [15:0]       k;
   logic [5:0]        sh_amt;
   logic [DATA_W-1:0] k_sh;
   logic [DATA_W-1:0] k_mask;
   logic [DATA_W-1:0] i_val;
   logic [DATA_W-1:0] d_val;
   logic [DATA_W-1:0] b_val;
   logic [DATA_W-1:0] cb_val;
   logic              mw_ill;
   logic [DATA_W-1:0] dec_val;
   logic              dec_err;
   logic              unused_imm_hi;

   // pipeline storage: output register (OR) and skid register (SK)
   logic              or_vld_q, or_vld_d;
   logic [DATA_W-1:0] or_dat_q, or_dat_d;
   logic              or_err_q, or_err_d;
   logic              sk_vld_q, sk_vld_d;
   logic [DATA_W-1:0] sk_dat_q, sk_dat_d;
   logic              sk_err_q, sk_err_d;
   logic                 sticky_q, sticky_d;
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

   logic acc;
   logic oxf;

   assign unused_imm_hi = ^bus.Imm32[31:26];

   always_comb begin
      fmt    = fmt_e'(bus.Ctrl);
      hw     = bus.Imm32[22:21];
      k      = bus.Imm32[20:5];
      sh_amt = {hw, 4'b0000};
      k_sh   = {{(DATA_W-16){1'b0}}, k} << sh_amt;
      k_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF} << sh_amt;
      i_val  = {{(DATA_W-24){1'b0}},
                (bus.Imm32[22] ? {bus.Imm32[21:10], 12'h000} : {12'h000, bus.Imm32[21:10]})};
      d_val  = {{(DATA_W-9){bus.Imm32[20]}}, bus.Imm32[20:12]};
      b_val  = {{(DATA_W-26){bus.Imm32[25]}}, bus.Imm32[25:0]} << BR_SH;
      cb_val = {{(DATA_W-19){bus.Imm32[23]}}, bus.Imm32[23:5]} << BR_SH;
      // a 32-bit operand has no halfwords 2 and 3
      mw_ill = NARROW & hw[1];
   end

   always_comb begin
      dec_val = '0;
      dec_err = 1'b0;
      case (fmt)
         FMT_I:  dec_val = i_val;
         FMT_D:  dec_val = d_val;
         FMT_B:  dec_val = b_val;
         FMT_CB: dec_val = cb_val;
         FMT_MZ: begin
            dec_err = mw_ill;
            dec_val = mw_ill ? '0 : k_sh;
         end
         FMT_MK: begin
            dec_err = mw_ill;
            dec_val = mw_ill ? '0 : ((bus.Merge & ~k_mask) | k_sh);
         end
         FMT_MN: begin
            dec_err = mw_ill;
            dec_val = mw_ill ? '0 : ~k_sh;
         end
         default: begin
            dec_err = 1'b1;
            dec_val = '0;
         end
      endcase
   end

   assign acc = bus.in_valid & ~sk_vld_q;
   assign oxf = or_vld_q & bus.out_ready;

   always_comb begin
      or_vld_d = or_vld_q;
      or_dat_d = or_dat_q;
      or_err_d = or_err_q;
      sk_vld_d = sk_vld_q;
      sk_dat_d = sk_dat_q;
      sk_err_d = sk_err_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;

      if (oxf) begin
         if (sk_vld_q) begin
            or_dat_d = sk_dat_q;
            or_err_d = sk_err_q;
            sk_vld_d = 1'b0;
         end else begin
            or_vld_d = 1'b0;
         end
      end

      // acc implies SK empty, so a draining OR can take the new result directly
      if (acc) begin
         if (!or_vld_q || oxf) begin
            or_vld_d = 1'b1;
            or_dat_d = dec_val;
            or_err_d = dec_err;
         end else begin
            sk_vld_d = 1'b1;
            sk_dat_d = dec_val;
            sk_err_d = dec_err;
         end
         if (dec_err) begin
            sticky_d = 1'b1;
            if (cnt_q != '1) begin
               cnt_d = cnt_q + ERR_CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         or_vld_q <= 1'b0;
         or_dat_q <= '0;
         or_err_q <= 1'b0;
         sk_vld_q <= 1'b0;
         sk_dat_q <= '0;
         sk_err_q <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         or_vld_q <= or_vld_d;
         or_dat_q <= or_dat_d;
         or_err_q <= or_err_d;
         sk_vld_q <= sk_vld_d;
         sk_dat_q <= sk_dat_d;
         sk_err_q <= sk_err_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.in_ready   = ~sk_vld_q;
   assign bus.out_valid  = or_vld_q;
   assign bus.BusImm     = or_dat_q;
   assign bus.out_err    = or_err_q;
   assign bus.err_sticky = sticky_q;
   assign bus.err_cnt    = cnt_q;

   a_stall_hold: assert property (@(posedge CLK) disable iff (Reset)
      (or_vld_q && !bus.out_ready) |=> (or_vld_q && $stable(or_dat_q) && $stable(or_err_q)));

   a_skid_behind_or: assert property (@(posedge CLK) disable iff (Reset)
      sk_vld_q |-> or_vld_q);

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboarded random and directed bench for imm_extend_pipe; three instances
// (64/scaled, 64/unscaled with 2-bit error counter, 32/scaled) share one stimulus stream.
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] imm = '0;
   logic [2:0]  ctrl = '0;
   logic [63:0] merge = '0;
   logic        out_ready = 1'b0;

   always #5 clk = ~clk;

   imm_extend_pipe_if #(.DATA_W(64), .ERR_CNT_W(8)) b0 ();
   imm_extend_pipe_if #(.DATA_W(64), .ERR_CNT_W(2)) b1 ();
   imm_extend_pipe_if #(.DATA_W(32), .ERR_CNT_W(8)) b2 ();

   assign b0.in_valid = in_valid;  assign b0.Imm32 = imm;  assign b0.Ctrl = ctrl;
   assign b0.Merge = merge;        assign b0.out_ready = out_ready;
   assign b1.in_valid = in_valid;  assign b1.Imm32 = imm;  assign b1.Ctrl = ctrl;
   assign b1.Merge = merge;        assign b1.out_ready = out_ready;
   assign b2.in_valid = in_valid;  assign b2.Imm32 = imm;  assign b2.Ctrl = ctrl;
   assign b2.Merge = merge[31:0];  assign b2.out_ready = out_ready;

   imm_extend_pipe #(.DATA_W(64), .SCALE_BR(1'b1), .ERR_CNT_W(8)) u0 (.CLK(clk), .Reset(Reset), .bus(b0));
   imm_extend_pipe #(.DATA_W(64), .SCALE_BR(1'b0), .ERR_CNT_W(2)) u1 (.CLK(clk), .Reset(Reset), .bus(b1));
   imm_extend_pipe #(.DATA_W(32), .SCALE_BR(1'b1), .ERR_CNT_W(8)) u2 (.CLK(clk), .Reset(Reset), .bus(b2));

   localparam int unsigned DW   [3] = '{64, 64, 32};
   localparam bit          SC   [3] = '{1'b1, 1'b0, 1'b1};
   localparam int unsigned CMAX [3] = '{255, 3, 255};

   logic        ov   [3];
   logic        rdy  [3];
   logic [64:0] act  [3];
   logic [7:0]  ecnt [3];
   logic        est  [3];

   assign ov[0] = b0.out_valid;  assign ov[1] = b1.out_valid;  assign ov[2] = b2.out_valid;
   assign rdy[0] = b0.in_ready;  assign rdy[1] = b1.in_ready;  assign rdy[2] = b2.in_ready;
   assign act[0] = {b0.out_err, b0.BusImm};
   assign act[1] = {b1.out_err, b1.BusImm};
   assign act[2] = {b2.out_err, 32'h0, b2.BusImm};
   assign ecnt[0] = b0.err_cnt;  assign ecnt[1] = {6'h0, b1.err_cnt};  assign ecnt[2] = b2.err_cnt;
   assign est[0] = b0.err_sticky; assign est[1] = b1.err_sticky; assign est[2] = b2.err_sticky;

   int total = 0;
   int bad   = 0;

   logic [64:0] sbq [3][$];
   int          occ = 0;
   int unsigned mcnt [3] = '{0, 0, 0};
   bit          mst  [3] = '{1'b0, 1'b0, 1'b0};
   bit          acc_d;

   task automatic chk(input string name, input logic [64:0] a, input logic [64:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   // Reference decode from the format table; result {err, value}.
   function automatic logic [64:0] ref_imm(input logic [31:0] im, input logic [2:0] c,
                                           input logic [63:0] mg, input int unsigned dw, input bit sc);
      logic [63:0] v, kk, field;
      bit          e;
      int unsigned hw;
      hw    = int'(im[22:21]);
      kk    = 64'(im[20:5]) << (16 * hw);
      field = 64'hFFFF << (16 * hw);
      e = 1'b0;
      v = '0;
      case (c)
         3'd0: v = 64'(im[21:10]) * (im[22] ? 64'd4096 : 64'd1);
         3'd1: v = 64'(longint'($signed(im[20:12])));
         3'd2: v = 64'(longint'($signed(im[25:0])) * (sc ? 4 : 1));
         3'd3: v = 64'(longint'($signed(im[23:5])) * (sc ? 4 : 1));
         3'd4: v = kk;
         3'd5: v = (mg & ~field) | kk;
         3'd6: v = ~kk;
         default: e = 1'b1;
      endcase
      if (c >= 3'd4 && c <= 3'd6 && dw == 32 && hw >= 2) e = 1'b1;
      if (e) v = '0;
      if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return {e, v};
   endfunction

   // One clock of stimulus; sideband outputs are checked against the occupancy model.
   task automatic cyc(input bit v, input logic [31:0] im, input logic [2:0] c, input logic [63:0] mg,
                      input bit ordy, input int ovi, input logic [64:0] ovx, output bit accepted);
      logic [64:0] e;
      bit          outx;
      @(posedge clk);
      #1;
      in_valid = v; imm = im; ctrl = c; merge = mg; out_ready = ordy;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("in_ready[%0d]", i), 65'(rdy[i]), 65'(occ < 2));
         chk($sformatf("out_valid[%0d]", i), 65'(ov[i]), 65'(occ > 0));
         chk($sformatf("err_cnt[%0d]", i), 65'(ecnt[i]), 65'(mcnt[i]));
         chk($sformatf("err_sticky[%0d]", i), 65'(est[i]), 65'(mst[i]));
      end
      accepted = v && (occ < 2);
      outx     = (occ > 0) && ordy;
      if (accepted) begin
         for (int i = 0; i < 3; i++) begin
            e = (i == ovi) ? ovx : ref_imm(im, c, mg, DW[i], SC[i]);
            sbq[i].push_back(e);
            if (e[64]) begin
               mst[i] = 1'b1;
               if (mcnt[i] < CMAX[i]) mcnt[i]++;
            end
         end
      end
      occ = occ + (accepted ? 1 : 0) - (outx ? 1 : 0);
   endtask

   task automatic req(input logic [31:0] im, input logic [2:0] c, input logic [63:0] mg,
                      input int ovi, input logic [64:0] ovx);
      cyc(1'b1, im, c, mg, 1'b1, ovi, ovx, acc_d);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      Reset = 1'b0;
      occ = 0;
      for (int i = 0; i < 3; i++) begin
         sbq[i].delete();
         mcnt[i] = 0;
         mst[i]  = 1'b0;
      end
      @(negedge clk);
      chk("reset_bus", act[0], 65'h0);
      chk("reset_out_valid", 65'(ov[0]), 65'h0);
      chk("reset_in_ready", 65'(rdy[0]), 65'h1);
   endtask

   // Monitor: every presented result must match the head of its queue.
   always @(negedge clk) begin
      if (!Reset) begin
         for (int i = 0; i < 3; i++) begin
            if (ov[i]) begin
               if (sbq[i].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL out_unexpected[%0d]: got %h expected nothing", i, act[i]);
               end else begin
                  chk($sformatf("result[%0d]", i), act[i], sbq[i][0]);
                  if (out_ready) void'(sbq[i].pop_front());
               end
            end
         end
      end
   end

   initial begin
      bit          acc;
      int          guard;
      logic [31:0] ri;
      logic [2:0]  rc;

      do_reset();

      // directed formats with constant expectations on the 64-bit/scaled instance
      req(32'h002A_F000, 3'd0, 64'h0, 0, {1'b0, 64'h0000_0000_0000_0ABC});
      req(32'h006A_F000, 3'd0, 64'h0, 0, {1'b0, 64'h0000_0000_00AB_C000});
      req(32'h001F_0000, 3'd1, 64'h0, 0, {1'b0, 64'hFFFF_FFFF_FFFF_FFF0});
      req(32'h03FF_FFFF, 3'd2, 64'h0, 0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFC});
      req(32'h0000_0200, 3'd3, 64'h0, 1, {1'b0, 64'h0000_0000_0000_0010});
      req(32'h0057_DDE0, 3'd5, 64'h1111_2222_3333_4444, 0, {1'b0, 64'h1111_BEEF_3333_4444});
      req(32'h0000_0020, 3'd6, 64'h0, 0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
      req(32'h0062_4680, 3'd4, 64'h0, 0, {1'b0, 64'h1234_0000_0000_0000});
      cyc(1'b0, '0, '0, '0, 1'b1, -1, '0, acc);

      // backpressure: A to OR, B to SK, C held by the source
      cyc(1'b1, 32'h0012_3400, 3'd0, 64'h0, 1'b0, -1, '0, acc);
      cyc(1'b1, 32'h0001_5000, 3'd1, 64'h0, 1'b0, -1, '0, acc);
      cyc(1'b1, 32'h0062_4680, 3'd4, 64'h0, 1'b0, -1, '0, acc);
      cyc(1'b1, 32'h0062_4680, 3'd4, 64'h0, 1'b0, -1, '0, acc);
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 10) begin
         cyc(1'b1, 32'h0062_4680, 3'd4, 64'h0, 1'b1, -1, '0, acc);
         guard++;
      end
      total++;
      if (!acc) begin
         bad++;
         $display("FAIL held_request: got not accepted expected accepted within 10 cycles");
      end
      for (int n = 0; n < 3; n++) cyc(1'b0, '0, '0, '0, 1'b1, -1, '0, acc);

      // illegal control, then halfword 2 (illegal only on the 32-bit instance)
      req(32'h0000_0000, 3'd7, 64'h0, 0, {1'b1, 64'h0});
      req(32'h0042_4680, 3'd4, 64'h0, 2, {1'b1, 64'h0});
      cyc(1'b0, '0, '0, '0, 1'b1, -1, '0, acc);

      // saturation of the 2-bit counter
      do_reset();
      for (int n = 0; n < 5; n++) req($urandom, 3'd7, 64'h0, -1, '0);
      cyc(1'b0, '0, '0, '0, 1'b1, -1, '0, acc);
      chk("err_cnt_saturate", 65'(ecnt[1]), 65'd3);

      // reset with OR and SK full, then a fresh request
      cyc(1'b1, 32'h0000_1000, 3'd0, 64'h0, 1'b0, -1, '0, acc);
      cyc(1'b1, 32'h0000_2000, 3'd0, 64'h0, 1'b0, -1, '0, acc);
      do_reset();
      chk("reset_err_cnt", 65'(ecnt[0]), 65'h0);
      req(32'h0002_8000, 3'd0, 64'h0, 0, {1'b0, 64'h0000_0000_0000_00A0});
      cyc(1'b0, '0, '0, '0, 1'b1, -1, '0, acc);

      // randomized traffic with random backpressure
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) do_reset();
         ri = $urandom;
         rc = 3'($urandom_range(0, 7));
         cyc($urandom_range(0, 3) != 0, ri, rc, {$urandom, $urandom},
             $urandom_range(0, 9) < 7, -1, '0, acc);
      end

      for (int n = 0; n < 6; n++) cyc(1'b0, '0, '0, '0, 1'b1, -1, '0, acc);
      for (int i = 0; i < 3; i++) chk($sformatf("drained[%0d]", i), 65'(sbq[i].size()), 65'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
